// File: rtl/module_program_loader.sv
// Boot-time program loader: parses a framed UART byte stream, writes
// little-endian 32-bit words to instruction RAM and holds the core in
// reset until a complete, checksum-valid image has been stored.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start byte 0xA5, other bytes ignored
// LEN_LO  | waiting for low byte of the word count
// LEN_HI  | waiting for high byte of the word count, range check
// DATA    | assembling payload bytes into words, one write per word
// CHECK   | waiting for the XOR checksum byte
// DONE    | image valid, core released, bytes ignored
// ERROR   | framing/length/checksum/timeout fault, core held in reset
module module_program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    input  logic                  load_req_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  cpu_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Timeout is a down-counter: loaded on every byte, error when it sits
    // at zero and still no byte arrives.
    localparam logic [TW-1:0]         TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]         TMO_ONE  = TW'(1);
    localparam logic [16:0]           CAPACITY = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   WIDX_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [7:0]            START_BYTE = 8'hA5;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            xor_q, xor_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [16:0]           len_rx;
    logic                  timed;
    logic                  busy_next;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        xor_d    = xor_q;
        tmo_d    = tmo_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        len_rx   = {1'b0, rx_data_i, len_lo_q};
        timed    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CHECK);

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == START_BYTE)) begin
                    state_d = S_LEN_LO;
                    xor_d   = 8'h00;
                    bcnt_d  = 2'd0;
                    tmo_d   = TMO_LOAD;
                end
            end
            S_LEN_LO: begin
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid_i) begin
                    len_d = len_rx[ADDR_WIDTH:0];
                    if (len_rx > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (len_rx == 17'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    xor_d  = xor_q ^ rx_data_i;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: word_d[7:0]   = rx_data_i;
                        2'd1: word_d[15:8]  = rx_data_i;
                        2'd2: word_d[23:16] = rx_data_i;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_data_i, word_q};
                            addr_d  = widx_q[ADDR_WIDTH-1:0];
                            widx_d  = widx_q + WIDX_ONE;
                            if ((widx_q + WIDX_ONE) == len_q) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (rx_valid_i) begin
                    state_d = (rx_data_i == xor_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (load_req_i) begin
                    state_d = S_IDLE;
                    widx_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed) begin
            if (rx_valid_i) begin
                tmo_d = TMO_LOAD;
            end else if (tmo_q == '0) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q - TMO_ONE;
            end
        end

        busy_next   = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                      (state_d == S_DATA)   || (state_d == S_CHECK);
        busy_d      = busy_next;
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        cpu_rst_n_d = (state_d == S_DONE);
    end

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            widx_q      <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            xor_q       <= '0;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            xor_q       <= xor_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_module_program_loader.sv
// Directed bench for the program loader with hand-computed expectations.
module tb_module_program_loader;

    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          load_req_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          cpu_rst_n_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    module_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .load_req_i  (load_req_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .cpu_rst_n_o (cpu_rst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every RAM write, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (mem_we_o) begin
            wr_addr.push_back(32'(mem_addr_o));
            wr_data.push_back(mem_wdata_o);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Sends tx_q back-to-back, one byte per cycle, then deasserts valid.
    task automatic send_q();
        foreach (tx_q[i]) begin
            @(negedge clk_i);
            rx_data_i  = tx_q[i];
            rx_valid_i = 1'b1;
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic pulse_load();
        @(negedge clk_i);
        load_req_i = 1'b1;
        @(negedge clk_i);
        load_req_i = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst_i      = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        load_req_i = 1'b0;
        repeat (3) @(negedge clk_i);

        check_val("rst_cpu",   32'(cpu_rst_n_o), 32'd0);
        check_val("rst_we",    32'(mem_we_o),    32'd0);
        check_val("rst_addr",  32'(mem_addr_o),  32'd0);
        check_val("rst_wdata", mem_wdata_o,      32'd0);
        check_val("rst_flags", {29'd0, busy_o, done_o, error_o}, 32'd0);
        rst_i = 1'b1;

        // Good two-word frame, payload XOR = 0xB0.
        clear_writes();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                 8'h93, 8'h05, 8'h20, 8'h00};
        send_q();
        check_val("t1_busy_pre", 32'(busy_o),      32'd1);
        check_val("t1_cpu_pre",  32'(cpu_rst_n_o), 32'd0);
        tx_q = '{8'hB0};
        send_q();
        check_val("t1_flags", {29'd0, busy_o, done_o, error_o}, 32'b010);
        check_val("t1_cpu",   32'(cpu_rst_n_o), 32'd1);
        check_val("t1_nwr",   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check_val("t1_a0", wr_addr[0], 32'd0);
            check_val("t1_d0", wr_data[0], 32'h00100513);
            check_val("t1_a1", wr_addr[1], 32'd1);
            check_val("t1_d1", wr_data[1], 32'h00200593);
        end

        // Bytes in DONE are ignored; load_req wins over a simultaneous 0xA5.
        tx_q = '{8'hA5, 8'h01};
        send_q();
        check_val("t1_done_hold", 32'(done_o), 32'd1);
        @(negedge clk_i);
        load_req_i = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hA5;
        @(negedge clk_i);
        load_req_i = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        check_val("lr_win", {28'd0, cpu_rst_n_o, busy_o, done_o, error_o}, 32'd0);

        // Same frame, checksum flipped.
        clear_writes();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
        send_q();
        check_val("t2_flags", {29'd0, busy_o, done_o, error_o}, 32'b001);
        check_val("t2_cpu",   32'(cpu_rst_n_o), 32'd0);
        @(negedge clk_i);
        check_val("t2_nwr",   32'(wr_addr.size()), 32'd2);
        if (wr_data.size() == 2) check_val("t2_d1", wr_data[1], 32'h00200593);
        pulse_load();
        check_val("t2_rearm", {29'd0, busy_o, done_o, error_o}, 32'd0);

        // Length 0x0401 exceeds the 1024-word capacity.
        clear_writes();
        tx_q = '{8'hA5, 8'h01, 8'h04};
        send_q();
        @(negedge clk_i);
        check_val("t3_err", 32'(error_o), 32'd1);
        check_val("t3_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_load();

        // Length 0x0400 is exactly capacity and must be accepted.
        tx_q = '{8'hA5, 8'h00, 8'h04};
        send_q();
        check_val("t3_cap", {29'd0, busy_o, done_o, error_o}, 32'b100);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Stall after 5 payload bytes: error exactly 16 cycles after last byte.
        clear_writes();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        send_q();
        repeat (15) @(negedge clk_i);
        check_val("t4_err_15", {29'd0, busy_o, done_o, error_o}, 32'b100);
        @(negedge clk_i);
        check_val("t4_err_16", {29'd0, busy_o, done_o, error_o}, 32'b001);
        check_val("t4_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check_val("t4_a0", wr_addr[0], 32'd0);
            check_val("t4_d0", wr_data[0], 32'h00100513);
        end
        pulse_load();

        // Garbage before the start byte, empty image.
        clear_writes();
        tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        check_val("t5_done", {28'd0, cpu_rst_n_o, busy_o, done_o, error_o}, 32'b1010);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h01};
        send_q();
        @(negedge clk_i);
        check_val("t5_nwr",  32'(wr_addr.size()), 32'd0);
        check_val("t5_hold", 32'(done_o), 32'd1);
        pulse_load();

        // Asynchronous reset in the middle of word 1.
        clear_writes();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
        send_q();
        check_val("t6_pre_wdata", mem_wdata_o, 32'h00100513);
        #2;
        rst_i = 1'b0;
        #1;
        check_val("t6_rst_wdata", mem_wdata_o, 32'd0);
        check_val("t6_rst_misc", {27'd0, mem_we_o, cpu_rst_n_o, busy_o, done_o, error_o}, 32'd0);
        check_val("t6_rst_addr", 32'(mem_addr_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_writes();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        send_q();
        @(negedge clk_i);
        check_val("t6_done", {28'd0, cpu_rst_n_o, busy_o, done_o, error_o}, 32'b1010);
        check_val("t6_nwr",  32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check_val("t6_a0", wr_addr[0], 32'd0);
            check_val("t6_d1", wr_data[1], 32'h00200593);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_program_loader.md
# module_program_loader

Boot-time program loader that sits upstream of the single-cycle core's instruction memory. It receives a framed byte stream from the UART receiver and assembles little-endian 32-bit words. It writes them sequentially into instruction RAM and holds the core in reset until a complete, checksum-valid image has been stored. On success it releases the core to fetch from address 0. On any framing, length, checksum or timeout error it keeps the core in reset and flags the error.

## Interface
- ADDR_WIDTH, 10, word-address width of instruction RAM; capacity 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clock cycles allowed between consecutive bytes once a frame has started.
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte from UART.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i is valid when high.
- load_req_i  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- mem_we_o  out  1  instruction RAM write enable, one-cycle pulse per word.
- mem_addr_o  out  ADDR_WIDTH  word address of the write.
- mem_wdata_o  out  32  assembled word.
- cpu_rst_n_o  out  1  active-low reset to core datapath/PC register; 0 while loading.
- busy_o  out  1  high from start byte until DONE or ERROR.
- done_o  out  1  high in DONE.
- error_o  out  1  high in ERROR.

## Operation
- Frame layout: start byte 0xA5; LEN_LO; LEN_HI (16-bit word count N); 4·N payload bytes, least-significant byte first; CHK byte equal to the XOR of all 4·N payload bytes.
- States and transitions:
  - IDLE: any byte other than 0xA5 is ignored. 0xA5 → LEN_LO.
  - LEN_LO: store the low length byte → LEN_HI.
  - LEN_HI: store the high length byte. If N > 2^ADDR_WIDTH → ERROR. If N = 0 → CHECK. Otherwise → DATA.
  - DATA: shift bytes into bits [7:0], [15:8], [23:16], [31:24] using a 2-bit byte counter. On the 4th byte, register the word and pulse mem_we_o. After word N-1 is written → CHECK.
  - CHECK: compare the received byte with the running XOR. Match → DONE. Mismatch → ERROR.
  - DONE: cpu_rst_n_o=1 and all bytes are ignored. load_req_i → IDLE with cpu_rst_n_o=0.
  - ERROR: cpu_rst_n_o=0 and bytes are ignored. load_req_i → IDLE.
- Word address counter:
  - Starts at 0 and increments after each write.
  - Cleared on entry to IDLE.
  - Never wraps, because the length check prevents N > capacity.
- Running XOR and byte counter are cleared on entry to LEN_LO.
- Inter-byte timeout:
  - A counter runs in LEN_LO, LEN_HI, DATA and CHECK.
  - It resets on every rx_valid_i.
  - Reaching TIMEOUT_CYCLES-1 without a byte → ERROR.
  - The counter is inactive in IDLE, DONE and ERROR.
- If load_req_i and rx_valid_i are both high in DONE/ERROR, load_req_i wins and the byte is discarded. The next 0xA5 starts a frame.
- load_req_i in IDLE, LEN_*, DATA or CHECK is ignored.

## Timing
- Reset values (rst_i=0, asynchronous):
  - state=IDLE.
  - cpu_rst_n_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - busy_o=0, done_o=0, error_o=0.
  - All counters and the XOR accumulator are 0.
- Reset asserted mid-frame aborts the frame immediately. Words already written remain in RAM; the core stays in reset.
- All state updates occur on the clk_i rising edge where rx_valid_i=1. No output depends combinationally on rx_data_i.
- Word write latency: mem_we_o, mem_addr_o and mem_wdata_o are registered. They are valid together for exactly one cycle, in the cycle after the edge that captured the 4th byte.
- Back-to-back bytes (rx_valid_i high on consecutive cycles) are supported at full rate. The write from word k may overlap byte reception for word k+1.
- cpu_rst_n_o rises one cycle after the edge that captures a matching CHK byte, coinciding with done_o. The core's first fetch is from PC=0 on the following edge.
- busy_o rises the cycle after 0xA5 is captured. It falls in the same cycle done_o or error_o rises.
- done_o and error_o are never high simultaneously.

## Test plan
- Reset release, then bytes A5 02 00 13 05 10 00 93 05 20 00 with CHK = XOR of the 8 payload bytes → two write pulses: addr0=0x00100513, addr1=0x00200593. Then done_o=1 and cpu_rst_n_o=1.
- Same frame with CHK flipped by 0x01 → both words written, error_o=1, cpu_rst_n_o stays 0. Then load_req_i pulse → IDLE with error_o=0.
- Length 0x0401 with ADDR_WIDTH=10 → error_o=1 after LEN_HI, with zero write pulses.
- Frame stalls after 5 payload bytes for TIMEOUT_CYCLES (set to 16) → error_o=1 exactly 16 cycles after the last byte. Exactly one write pulse occurs (addr 0).
- Garbage 0x00 0xFF before A5, N=0, CHK=0x00 → done_o=1 with no writes. Bytes sent afterwards cause no writes.
- rst_i pulled low in the middle of word 1 → all outputs return to reset values asynchronously. A full new frame after release loads correctly from addr 0.
